// File: rtl/perm_seq_controller.sv
// Sequencing control for the permutation datapath. It runs ITERATIONS rounds per
// block over 1..2^BLK_W-1 blocks and drives the datapath register and memory strobes.
module perm_seq_controller #(
  parameter int ITERATIONS = 64,
  parameter int CNT_W      = 6,
  parameter int BLK_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             hold,
  input  logic             abort,
  input  logic [BLK_W-1:0] num_blocks,
  output logic             reset_reg,
  output logic             load_reg,
  output logic             read_input,
  output logic             write_output,
  output logic             count,
  output logic             cout,
  output logic [CNT_W-1:0] iter,
  output logic [BLK_W-1:0] blk,
  output logic             ready,
  output logic             done,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_INIT  = 3'd2,
    S_LOAD  = 3'd3,
    S_ROUND = 3'd4,
    S_WRITE = 3'd5,
    S_DONE  = 3'd6,
    S_ILL   = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERATIONS - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_iter;
  logic [BLK_W-1:0] r_blk;
  logic [BLK_W-1:0] r_nb;

  logic w_abort;
  logic w_arm_go;
  logic w_last_blk;
  logic w_count;
  logic w_cout;

  // Abort is meaningless in IDLE, so it never blocks a start from there.
  assign w_abort    = abort && (r_state != S_IDLE);
  assign w_arm_go   = (r_state == S_ARMED) && !start;
  assign w_last_blk = (r_blk == (r_nb - BLK_W'(1)));
  assign w_count    = (r_state == S_ROUND) && !hold;
  assign w_cout     = w_count && (r_iter == LAST_ITER);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (w_abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start) w_next = S_ARMED;
        S_ARMED: if (!start) w_next = S_INIT;
        S_INIT:  w_next = S_LOAD;
        S_LOAD:  w_next = S_ROUND;
        S_ROUND: if (w_cout) w_next = S_WRITE;
        S_WRITE: w_next = w_last_blk ? S_DONE : S_LOAD;
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Iteration/block counters; iter wraps on the same edge that leaves ROUND.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_iter <= '0;
      r_blk  <= '0;
      r_nb   <= BLK_W'(1);
    end else if (w_abort) begin
      r_iter <= '0;
      r_blk  <= '0;
    end else if (w_arm_go) begin
      r_iter <= '0;
      r_blk  <= '0;
      r_nb   <= (num_blocks == '0) ? BLK_W'(1) : num_blocks;
    end else begin
      if (w_count) begin
        r_iter <= w_cout ? '0 : r_iter + CNT_W'(1);
      end
      if ((r_state == S_WRITE) && !w_last_blk) begin
        r_blk <= r_blk + BLK_W'(1);
      end
    end
  end

  always_comb begin
    reset_reg    = 1'b0;
    load_reg     = 1'b0;
    read_input   = 1'b0;
    write_output = 1'b0;
    ready        = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE:  ready = 1'b1;
      S_INIT:  reset_reg = 1'b1;
      S_LOAD: begin
        read_input = 1'b1;
        load_reg   = 1'b1;
      end
      S_ROUND: load_reg = w_count;
      S_WRITE: write_output = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign count = w_count;
  assign cout  = w_cout;
  assign iter  = r_iter;
  assign blk   = r_blk;
  assign state = r_state;

endmodule

// File: tb/tb_perm_seq_controller.sv
// Bench for perm_seq_controller: table of whole-run scenarios plus hand-written
// sequences for abort, start re-arm and asynchronous reset.
module tb_perm_seq_controller;

  localparam int ITERATIONS = 64;
  localparam int CNT_W      = 6;
  localparam int BLK_W      = 4;
  localparam int LIMIT      = 2000;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             hold;
  logic             abort;
  logic [BLK_W-1:0] num_blocks;
  logic             reset_reg, load_reg, read_input, write_output;
  logic             count, cout, ready, done;
  logic [CNT_W-1:0] iter;
  logic [BLK_W-1:0] blk;
  logic [2:0]       state;

  perm_seq_controller #(
    .ITERATIONS(ITERATIONS), .CNT_W(CNT_W), .BLK_W(BLK_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .hold(hold), .abort(abort),
    .num_blocks(num_blocks), .reset_reg(reset_reg), .load_reg(load_reg),
    .read_input(read_input), .write_output(write_output), .count(count),
    .cout(cout), .iter(iter), .blk(blk), .ready(ready), .done(done),
    .state(state)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    int nb;
    bit do_hold;
    int abort_at;
    int cycles;
    int reads;
    int writes;
    int dones;
    int couts;
    int loads;
    int counts;
    int blk_end;
  } vec_t;

  vec_t tbl[8];

  // Per-run statistics gathered by run_vec
  int e, n_rr, n_rd, n_wr, n_dn, n_co, n_ld, n_ct, bad, armed_bad;
  int first_rr, first_rd, dn_at, e_iter, prev_iter;
  bit prev_hold_round;

  task automatic run_vec(input int nb, input bit do_hold, input int abort_at);
    int  hold_left;
    bit  h1, h2, ab_done;
    n_rr = 0; n_rd = 0; n_wr = 0; n_dn = 0; n_co = 0; n_ld = 0; n_ct = 0;
    bad = 0; armed_bad = 0; first_rr = -1; first_rd = -1; dn_at = -1;
    e_iter = 0; prev_iter = 0; prev_hold_round = 1'b0;
    hold_left = 0; h1 = 1'b0; h2 = 1'b0; ab_done = 1'b0;
    num_blocks = BLK_W'(nb);
    @(negedge clk);
    start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      if (state != 3'd1) armed_bad++;
    end
    start = 1'b0;
    e = -1;
    for (int k = 0; k < LIMIT; k++) begin
      @(negedge clk);
      e++;
      if (do_hold && state == 3'd4 && hold_left == 0 &&
          ((iter == 6'd10 && !h1) || (iter == 6'd63 && !h2))) begin
        hold_left = 5;
        if (iter == 6'd10) h1 = 1'b1; else h2 = 1'b1;
      end
      hold = (hold_left > 0);
      if (hold_left > 0) hold_left--;
      if (abort_at >= 0 && state == 3'd4 && int'(iter) == abort_at && !ab_done) begin
        abort = 1'b1;
        ab_done = 1'b1;
      end else begin
        abort = 1'b0;
      end
      #1;
      if (reset_reg) begin n_rr++; if (first_rr < 0) first_rr = e; end
      if (read_input) begin
        n_rd++;
        if (first_rd < 0) first_rd = e;
        if (int'(blk) != n_rd - 1) bad++;
      end
      if (write_output) begin n_wr++; if (iter != 0) bad++; end
      if (done) begin n_dn++; dn_at = e; end
      if (cout) begin n_co++; if (iter != 6'd63) bad++; end
      if (load_reg) n_ld++;
      if (count) begin
        n_ct++;
        if (int'(iter) != e_iter) bad++;
        e_iter = (e_iter + 1) % ITERATIONS;
      end
      if (hold && state == 3'd4 && (count || cout)) bad++;
      if (prev_hold_round && int'(iter) != prev_iter) bad++;
      prev_hold_round = hold && (state == 3'd4);
      prev_iter = int'(iter);
      if (state == 3'd0) break;
    end
    hold = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_round_iter(input int it, output bit found);
    found = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      #1;
      if (state == 3'd4 && int'(iter) == it) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit found;
    int wr;

    tbl[0] = '{1,  1'b0, -1, 68,  1,  1,  1, 1,  65,  64,  0};
    tbl[1] = '{3,  1'b0, -1, 200, 3,  3,  1, 3,  195, 192, 2};
    tbl[2] = '{0,  1'b0, -1, 68,  1,  1,  1, 1,  65,  64,  0};
    tbl[3] = '{1,  1'b1, -1, 78,  1,  1,  1, 1,  65,  64,  0};
    tbl[4] = '{1,  1'b0, 30, 33,  1,  0,  0, 0,  32,  31,  0};
    tbl[5] = '{1,  1'b0, -1, 68,  1,  1,  1, 1,  65,  64,  0};
    tbl[6] = '{2,  1'b1, -1, 144, 2,  2,  1, 2,  130, 128, 1};
    tbl[7] = '{15, 1'b0, -1, 992, 15, 15, 1, 15, 975, 960, 14};

    reset = 1'b1; start = 1'b0; hold = 1'b0; abort = 1'b0; num_blocks = '0;
    #1;
    check("rst_state", int'(state), 0);
    check("rst_ready", int'(ready), 1);
    check("rst_iter", int'(iter), 0);
    check("rst_blk", int'(blk), 0);
    check("rst_strobes", int'({reset_reg, load_reg, read_input, write_output, count, cout, done}), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    hold = 1'b1;
    #1;
    check("idle_hold_count", int'(count), 0);
    hold = 1'b0;

    // Abort while ARMED with start still high
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    #1;
    check("armed_state", int'(state), 1);
    abort = 1'b1;
    @(negedge clk);
    #1;
    check("abort_armed_state", int'(state), 0);
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    #1;
    check("abort_armed_stay_idle", int'(state), 0);

    for (int i = 0; i < 8; i++) begin
      run_vec(tbl[i].nb, tbl[i].do_hold, tbl[i].abort_at);
      check($sformatf("v%0d_armed_wait", i), armed_bad, 0);
      check($sformatf("v%0d_cycles", i), e, tbl[i].cycles);
      check($sformatf("v%0d_end_state", i), int'(state), 0);
      check($sformatf("v%0d_end_ready", i), int'(ready), 1);
      check($sformatf("v%0d_end_iter", i), int'(iter), 0);
      check($sformatf("v%0d_end_blk", i), int'(blk), tbl[i].blk_end);
      check($sformatf("v%0d_reset_reg", i), n_rr, 1);
      check($sformatf("v%0d_rr_at", i), first_rr, 0);
      check($sformatf("v%0d_rd_at", i), first_rd, 1);
      check($sformatf("v%0d_reads", i), n_rd, tbl[i].reads);
      check($sformatf("v%0d_writes", i), n_wr, tbl[i].writes);
      check($sformatf("v%0d_dones", i), n_dn, tbl[i].dones);
      check($sformatf("v%0d_couts", i), n_co, tbl[i].couts);
      check($sformatf("v%0d_loads", i), n_ld, tbl[i].loads);
      check($sformatf("v%0d_counts", i), n_ct, tbl[i].counts);
      check($sformatf("v%0d_seq_errors", i), bad, 0);
      if (tbl[i].dones > 0) check($sformatf("v%0d_done_at", i), dn_at, tbl[i].cycles - 1);
    end

    // start raised mid-run and kept high through DONE, then re-arms from IDLE
    num_blocks = BLK_W'(1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    #1;
    check("rearm_armed", int'(state), 1);
    start = 1'b0;
    @(negedge clk);
    #1;
    check("rearm_init", int'(state), 2);
    wait_round_iter(20, found);
    check("rearm_reach_round", int'(found), 1);
    start = 1'b1;
    wr = 0;
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      #1;
      if (write_output) wr++;
      if (state == 3'd6) begin found = 1'b1; break; end
    end
    check("rearm_reach_done", int'(found), 1);
    check("rearm_writes", wr, 1);
    @(negedge clk);
    #1;
    check("rearm_idle_after_done", int'(state), 0);
    @(negedge clk);
    #1;
    check("rearm_armed_again", int'(state), 1);
    start = 1'b0;
    @(negedge clk);
    #1;
    check("rearm_init_again", int'(state), 2);
    abort = 1'b1;
    @(negedge clk);
    #1;
    check("abort_init_state", int'(state), 0);
    check("abort_init_ready", int'(ready), 1);
    abort = 1'b0;

    // Asynchronous reset between clock edges in ROUND
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_round_iter(20, found);
    check("areset_reach_round", int'(found), 1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("areset_state", int'(state), 0);
    check("areset_iter", int'(iter), 0);
    check("areset_ready", int'(ready), 1);
    check("areset_load_count", int'({load_reg, count}), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("areset_stay_idle", int'(state), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
